sram_like_mem_slave: RTL
========================

SRAM_LIKE_MEM_SLAVE -- requirements
Module: sram_like_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of the backing RAM port.
REQ-002 Parameter LAT, default 2, extra wait cycles before each RAM access; legal range 0..7.
REQ-003 Parameter DEPTH, default 2, maximum accepted-but-unanswered requests; power of two, at least 2.
REQ-004 clk  in  1  sole clock; every register updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  sram-like request valid; the master holds it until addr_ok.
REQ-007 wr  in  1  1 = write, 0 = read; qualified by req.
REQ-008 size  in  2  transfer size: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  write data, already lane-positioned by the master.
REQ-011 addr_ok  out  1  request accepted this cycle when req is also 1.
REQ-012 data_ok  out  1  one-cycle pulse that completes the oldest accepted request.
REQ-013 rdata  out  32  full read word, valid only while data_ok=1.
REQ-014 ram_en  out  1  RAM access strobe.
REQ-015 ram_wen  out  4  RAM byte write enables; 0 for reads.
REQ-016 ram_addr  out  ADDR_W  RAM word address, addr[ADDR_W+1:2].
REQ-017 ram_wdata  out  32  RAM write data.
REQ-018 ram_rdata  in  32  RAM read data, valid one cycle after ram_en.

Function
REQ-019 The block SHALL drive addr_ok = !full, decoded from registered FIFO occupancy only, with no combinational path from req or from a same-cycle pop.
REQ-020 An address handshake (req & addr_ok) SHALL push {wr, size, addr, wdata} into an in-order FIFO of DEPTH entries.
REQ-021 The access FSM SHALL have states IDLE, WAIT, ISSUE and RESP.
REQ-022 IDLE: if the FIFO is non-empty, go to ISSUE when LAT=0; otherwise load cnt=LAT-1 and go to WAIT.
REQ-023 WAIT: go to ISSUE when cnt=0; otherwise decrement cnt.
REQ-024 ISSUE: assert ram_en for exactly one cycle with the FIFO head's ram_addr, ram_wen and ram_wdata, then go to RESP.
REQ-025 RESP: assert data_ok for exactly one cycle and pop the head.
REQ-026 RESP exit: if another entry remains after the pop, apply the IDLE decision directly (no IDLE cycle); otherwise go to IDLE.
REQ-027 Latency: a request accepted in cycle T into an empty idle block SHALL see data_ok in cycle T+3+LAT.
REQ-028 Throughput: back-to-back requests SHALL complete one per LAT+2 cycles.
REQ-029 ram_wen for reads SHALL be 4'b0000.
REQ-030 ram_wen for a byte write SHALL be 4'b0001 << addr[1:0].
REQ-031 ram_wen for a half write SHALL be 4'b1100 if addr[1]=1, else 4'b0011; addr[0] is ignored.
REQ-032 ram_wen for a word write (size 2 or 3) SHALL be 4'b1111; addr[1:0] is ignored.
REQ-033 In RESP, rdata SHALL equal ram_rdata for reads and 0 for writes; rdata SHALL be 0 whenever data_ok=0.
REQ-034 A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL preserve order.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH.
REQ-036 A push while full is impossible because addr_ok=0; req with addr_ok=0 SHALL change no state.
REQ-037 When idle and empty, ram_en and data_ok SHALL stay 0.

Reset
REQ-038 While rst=1 the block SHALL force: state IDLE, FIFO empty, cnt=0, addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_wen=0, ram_addr=0, ram_wdata=0.
REQ-039 addr_ok SHALL rise in the first cycle after rst deasserts.
REQ-040 Reset mid-operation SHALL discard all pending requests without issuing data_ok for any of them.

Structure
REQ-041 A shared package sram_like_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the request-entry struct.
REQ-042 The FIFO SHALL be the sub-module sram_like_req_fifo (push, pop, full, empty, head).
REQ-043 The FSM, latency counter and byte-enable decode SHALL live in sram_like_mem_slave.

Verification
REQ-044 LAT=0: read word at addr 0x10, RAM word 4 = 0xDEADBEEF -> data_ok exactly 3 cycles after the handshake, rdata=0xDEADBEEF.
REQ-045 LAT=2: byte write addr 0x7, wdata 0xAA000000 -> one ram_en with ram_wen=4'b1000, ram_addr=1; data_ok 5 cycles after the handshake with rdata=0.
REQ-046 Three back-to-back requests with req held high -> addr_ok drops after 2 accepts; data_ok pulses in acceptance order, spaced LAT+2 cycles apart.
REQ-047 Half write at addr 0x6 (size=1) -> ram_wen=4'b1100; half write at addr 0x5 -> ram_wen=4'b0011.
REQ-048 rst asserted in WAIT with 2 pending -> no data_ok, ram_en=0; addr_ok=1 in the first cycle after reset; a new read completes normally.
REQ-049 Random req/wr/size traffic against a reference memory model -> every read matches the model, one data_ok per accepted request, no data_ok without a pending request.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types for the sram-like memory slave.
// Holds size codes, FSM states and the queued request entry.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order request FIFO between address and data phases.
// DEPTH must be a power of two so the pointers wrap for free.
module sram_like_req_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  req_t                     din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output req_t                     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    req_t          mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_like_mem_slave.sv
// SRAM-like slave: queues address handshakes, then runs each one
// through a wait/issue/respond sequence against a single-port RAM.
module sram_like_mem_slave
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT    = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ram_en_q, ram_en_d;
    logic        data_ok_q, data_ok_d;
    logic        launch;
    logic        push, pop, full, empty;
    logic [AW:0] count;
    req_t        entry, head;
    logic        unused_addr;

    function automatic logic [3:0] byte_en(input req_t r);
        logic [3:0] be;
        be = 4'b0000;
        if (r.wr) begin
            unique case (1'b1)
                (r.size == SZ_BYTE): be = 4'b0001 << r.addr[1:0];
                (r.size == SZ_HALF): be = r.addr[1] ? 4'b1100 : 4'b0011;
                default:             be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Acceptance depends only on registered occupancy, never on req or pop.
    assign addr_ok = !rst && !full;
    assign push    = req && addr_ok;
    assign entry   = '{wr: wr, size: size, addr: addr, wdata: wdata};

    sram_like_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_en_d  = 1'b0;
        data_ok_d = 1'b0;
        pop       = 1'b0;
        launch    = 1'b0;
        unique case (state_q)
            ST_IDLE: launch = !empty;
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d  = ST_ISSUE;
                    ram_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_RESP;
                data_ok_d = 1'b1;
            end
            ST_RESP: begin
                pop     = 1'b1;
                state_d = ST_IDLE;
                launch  = (count > (AW+1)'(1));
            end
            default: state_d = ST_IDLE;
        endcase
        // Shared start decision for a fresh idle entry or a chained one.
        if (launch) begin
            if (LAT == 0) begin
                state_d  = ST_ISSUE;
                ram_en_d = 1'b1;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            ram_en_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ram_en_q  <= ram_en_d;
            data_ok_q <= data_ok_d;
        end
    end

    assign ram_en    = ram_en_q && !rst;
    assign ram_wen   = ram_en ? byte_en(head) : 4'b0000;
    assign ram_addr  = ram_en ? head.addr[ADDR_W+1:2] : '0;
    assign ram_wdata = ram_en ? head.wdata : '0;
    assign data_ok   = data_ok_q && !rst;
    assign rdata     = (data_ok && !head.wr) ? ram_rdata : '0;

    assign unused_addr = ^head.addr;

endmodule
